// File: rtl/timing_gen.sv
// Bus frame timing generator: splits each frame into a pi (SPI-side) phase and a
// CPU phase, producing phi0, bus enable, RDY and registered RAM strobes.
module timing_gen #(
  parameter int CYCLE_CLKS = 16
) (
  input  logic                          clk_sys_i,
  input  logic                          reset_ni,
  input  logic [1:0]                    cpu_speed_i,
  input  logic                          cpu_halt_i,
  input  logic                          cpu_rw_ni,
  input  logic                          pi_req_i,
  input  logic                          pi_rw_ni,
  output logic                          pi_ack_o,
  output logic                          clk_cpu_o,
  output logic                          cpu_be_o,
  output logic                          cpu_ready_o,
  output logic                          ram_oe_no,
  output logic                          ram_we_no,
  output logic [$clog2(CYCLE_CLKS)-1:0] cycle_o
);

  localparam int CW = $clog2(CYCLE_CLKS);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] TWO       = CW'(2);
  localparam logic [CW-1:0] LAST      = CW'(CYCLE_CLKS - 1);
  localparam logic [CW-1:0] HALF      = CW'(CYCLE_CLKS / 2);
  localparam logic [CW-1:0] PI_ACK_AT = CW'(CYCLE_CLKS / 2 - 1);
  localparam logic [CW-1:0] PI_END    = CW'(CYCLE_CLKS / 2 - 2);
  localparam logic [CW-1:0] CPU_OE_AT = CW'(CYCLE_CLKS / 2 + 1);
  localparam logic [CW-1:0] CPU_WE_AT = CW'(CYCLE_CLKS / 2 + 2);
  localparam logic [CW-1:0] CPU_END   = CW'(CYCLE_CLKS - 2);

  if ((CYCLE_CLKS % 2) != 0 || CYCLE_CLKS < 8) begin : g_bad_cycle_clks
    $error("timing_gen: CYCLE_CLKS must be even and >= 8");
  end

  logic          first_q, req_q, prw_q, halt_q, crw_q;
  logic [1:0]    spd_q;
  logic [2:0]    div_q;

  logic [CW-1:0] cnt_n;
  logic          sample, req_n, prw_n, halt_n, crw_n, en_n;
  logic [1:0]    spd_n;
  logic [2:0]    div_n;
  logic          clk_n, be_n, oe_n, we_n, ack_n, rdy_n;

  // Outputs are computed for the count being entered, so every output is a
  // flop yet lines up with cycle_o; first_q makes the release edge a boundary.
  always_comb begin
    cnt_n  = (cycle_o == LAST) ? '0 : cycle_o + ONE;
    sample = first_q || (cnt_n == '0);
    req_n  = req_q;
    prw_n  = prw_q;
    spd_n  = spd_q;
    halt_n = halt_q;
    div_n  = div_q;
    if (sample) begin
      req_n  = pi_req_i;
      prw_n  = pi_rw_ni;
      spd_n  = cpu_speed_i;
      halt_n = cpu_halt_i;
      if (first_q || (cpu_speed_i != spd_q)) div_n = '0;
      else                                   div_n = div_q + 3'd1;
    end
    crw_n = (cnt_n == HALF) ? cpu_rw_ni : crw_q;

    case (spd_n)
      2'b00:   en_n = 1'b1;
      2'b01:   en_n = (div_n[0] == 1'b0);
      2'b10:   en_n = (div_n[1:0] == 2'b00);
      default: en_n = (div_n == 3'b000);
    endcase

    clk_n = 1'b0;
    be_n  = 1'b1;
    oe_n  = 1'b1;
    we_n  = 1'b1;
    ack_n = 1'b0;
    rdy_n = !halt_n;
    if (cnt_n < HALF) begin
      if (req_n) begin
        be_n  = 1'b0;
        oe_n  = !(prw_n && cnt_n >= ONE && cnt_n <= PI_END);
        we_n  = !(!prw_n && cnt_n >= TWO && cnt_n <= PI_END);
        ack_n = (cnt_n == PI_ACK_AT);
      end
    end else if (en_n) begin
      clk_n = 1'b1;
      oe_n  = !(crw_n && cnt_n >= CPU_OE_AT && cnt_n <= CPU_END);
      we_n  = !(!crw_n && cnt_n >= CPU_WE_AT && cnt_n <= CPU_END);
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (!reset_ni) begin
      cycle_o     <= '0;
      first_q     <= 1'b1;
      req_q       <= 1'b0;
      prw_q       <= 1'b1;
      spd_q       <= 2'b00;
      halt_q      <= 1'b0;
      div_q       <= 3'b000;
      crw_q       <= 1'b1;
      clk_cpu_o   <= 1'b0;
      cpu_be_o    <= 1'b0;
      cpu_ready_o <= 1'b0;
      ram_oe_no   <= 1'b1;
      ram_we_no   <= 1'b1;
      pi_ack_o    <= 1'b0;
    end else begin
      cycle_o     <= cnt_n;
      first_q     <= 1'b0;
      req_q       <= req_n;
      prw_q       <= prw_n;
      spd_q       <= spd_n;
      halt_q      <= halt_n;
      div_q       <= div_n;
      crw_q       <= crw_n;
      clk_cpu_o   <= clk_n;
      cpu_be_o    <= be_n;
      cpu_ready_o <= rdy_n;
      ram_oe_no   <= oe_n;
      ram_we_no   <= we_n;
      pi_ack_o    <= ack_n;
    end
  end

endmodule

// File: doc/timing_gen.md
TIMING_GEN -- requirements
Module: timing_gen

Interface
REQ-001 SHALL have parameter CYCLE_CLKS, default 16, meaning system clocks per bus frame; legal values are even and >= 8; elaboration SHALL fail otherwise.
REQ-002 SHALL have port clk_sys_i  in  1  system clock (16 MHz); one clock, all logic on rising edge.
REQ-003 SHALL have port reset_ni  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port cpu_speed_i  in  2  CPU frame divider: 00 every frame, 01 every 2nd, 10 every 4th, 11 every 8th.
REQ-005 SHALL have port cpu_halt_i  in  1  1 = request CPU halt.
REQ-006 SHALL have port cpu_rw_ni  in  1  CPU R/W (1 = read).
REQ-007 SHALL have port pi_req_i  in  1  SPI-side bus access request, level, held until ack.
REQ-008 SHALL have port pi_rw_ni  in  1  SPI access direction (1 = read).
REQ-009 SHALL have port pi_ack_o  out  1  one-clock pulse: SPI access complete.
REQ-010 SHALL have port clk_cpu_o  out  1  CPU phi0 clock.
REQ-011 SHALL have port cpu_be_o  out  1  CPU bus enable.
REQ-012 SHALL have port cpu_ready_o  out  1  CPU RDY (0 = halt).
REQ-013 SHALL have port ram_oe_no  out  1  RAM output enable, active-low.
REQ-014 SHALL have port ram_we_no  out  1  RAM write enable, active-low.
REQ-015 SHALL have port cycle_o  out  $clog2(CYCLE_CLKS)  current frame clock index c.

Function
REQ-016 SHALL count c from 0 to CYCLE_CLKS-1, wrapping to 0; H = CYCLE_CLKS/2; c = 0 is the frame boundary.
REQ-017 SHALL, at c = 0, sample pi_req_i, pi_rw_ni, cpu_speed_i and cpu_halt_i into frame registers; these SHALL NOT change mid-frame.
REQ-018 SHALL maintain a 3-bit frame divider, reset to 0 when the sampled cpu_speed_i changes; frame is CPU-enabled when divider bits below the selected ratio are all zero.
REQ-019 SHALL keep all outputs registered (no combinational path from inputs to outputs).
REQ-020 Pi phase (c in 0..H-1), request sampled: cpu_be_o = 0 for the whole phase; read -> ram_oe_no = 0 for c in 1..H-2; write -> ram_we_no = 0 for c in 2..H-2; pi_ack_o = 1 at c = H-1 only.
REQ-021 Pi phase, no request sampled: cpu_be_o = 1, ram_oe_no = ram_we_no = 1, pi_ack_o = 0.
REQ-022 CPU phase (c in H..CYCLE_CLKS-1), CPU-enabled frame: clk_cpu_o = 1; cpu_be_o = 1; cpu_rw_ni = 1 -> ram_oe_no = 0 for c in H+1..CYCLE_CLKS-2; cpu_rw_ni = 0 -> ram_we_no = 0 for c in H+2..CYCLE_CLKS-2.
REQ-023 CPU phase, non-enabled frame: clk_cpu_o = 0 (stretched low); RAM strobes deasserted; cpu_be_o = 1.
REQ-024 clk_cpu_o SHALL be 0 throughout every pi phase.
REQ-025 cpu_ready_o SHALL equal NOT sampled cpu_halt_i, updating only at c = 0; a halt asserted mid-frame takes effect next frame.
REQ-026 pi_req_i still high at the c = 0 after an ack SHALL start a new access (back-to-back, one per frame max).
REQ-027 ram_oe_no and ram_we_no SHALL never be 0 on the same clock.
REQ-028 cpu_rw_ni SHALL be sampled at c = H and held for the CPU phase.

Reset
REQ-029 While reset_ni = 0 at a rising edge, next state: c = 0, divider = 0, clk_cpu_o = 0, cpu_be_o = 0, cpu_ready_o = 0, ram_oe_no = 1, ram_we_no = 1, pi_ack_o = 0, frame registers cleared (no pi request).
REQ-030 Reset asserted mid-frame SHALL abort any access; no pi_ack_o for the aborted access; strobes deassert on the next edge.
REQ-031 First frame after reset release SHALL begin at c = 0 and sample inputs normally.

Verification
REQ-032 N=16, speed 00, no pi_req, cpu read -> clk_cpu_o high c=8..15 every frame, ram_oe_no low c=9..14, cpu_be_o constant 1.
REQ-033 pi_req_i=1, pi_rw_ni=0 before c=0 -> cpu_be_o low c=0..7, ram_we_no low c=2..6, pi_ack_o pulse at c=7; req held -> repeats next frame.
REQ-034 speed 10 -> clk_cpu_o pulses in frames 0,4,8 only; change to 00 mid-frame -> every frame starting next boundary, divider reset.
REQ-035 cpu_halt_i raised at c=5 -> cpu_ready_o falls at next c=0, not before; lowered -> rises at following c=0.
REQ-036 reset_ni low at c=4 during pi write -> next edge ram_we_no=1, cpu_be_o=0, no ack; after release c restarts at 0.
REQ-037 All scenarios: checker asserts REQ-027 and REQ-024 every clock.
